// File: rtl/bn_pkg.sv
// bn_pkg -- shared types and constants for the bits-needed refill controller.
// Rev 1.0
`default_nettype none

package bn_pkg;

  localparam int BYTE_W  = 8;
  localparam int BN_INIT = -8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_BYTE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bn_step.sv
// bn_step -- combinational step datapath: shift clamp, signed add, sign test, refill counter value.
// Rev 1.0
`default_nettype none

module bn_step
  import bn_pkg::*;
#(
  parameter int CNT_W     = 5,
  parameter int MAX_SHIFT = 8,
  parameter int SHIFT_W   = 4
) (
  input  logic signed [CNT_W-1:0]   i_bits_needed,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic        [CNT_W-1:0]   i_pend_pos,
  output logic signed [CNT_W-1:0]   o_sum,
  output logic                      o_sum_ge0,
  output logic                      o_clamped,
  output logic signed [CNT_W-1:0]   o_refill_bn
);

  localparam logic [SHIFT_W-1:0] c_max_shift = SHIFT_W'(MAX_SHIFT);
  localparam logic [CNT_W-1:0]   c_byte_w    = CNT_W'(BYTE_W);

  logic [SHIFT_W-1:0] w_eff_shift;

  assign o_clamped   = (i_shift > c_max_shift);
  assign w_eff_shift = o_clamped ? c_max_shift : i_shift;

  // Shift is zero-extended so it always adds as a non-negative quantity.
  assign o_sum       = i_bits_needed + $signed(CNT_W'(w_eff_shift));
  assign o_sum_ge0   = ~o_sum[CNT_W-1];
  assign o_refill_bn = $signed(i_pend_pos) - $signed(c_byte_w);

endmodule

`default_nettype wire

// File: rtl/bn_refill_ctrl.sv
// bn_refill_ctrl -- tracks bits-needed and requests one bitstream byte when it goes non-negative.
// Rev 1.0. Optional byte counter enabled by defining BN_REFILL_STATS_EN.
`default_nettype none

module bn_refill_ctrl
  import bn_pkg::*;
#(
  parameter int CNT_W     = 5,
  parameter int MAX_SHIFT = 8,
  parameter int SHIFT_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      init,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic                      op_bypass,
  input  logic        [SHIFT_W-1:0] op_shift,
  input  logic                      byte_valid,
  input  logic        [BYTE_W-1:0]  byte_data,
  output logic                      byte_ready,
  output logic                      refill_valid,
  output logic        [BYTE_W-1:0]  refill_data,
  output logic        [CNT_W-1:0]   refill_pos,
  output logic signed [CNT_W-1:0]   bits_needed,
  output logic                      err,
  output logic        [31:0]        byte_cnt
);

  localparam logic signed [CNT_W-1:0] c_bn_init = CNT_W'(BN_INIT);

  state_e                    r_state;
  logic signed [CNT_W-1:0]   r_bits_needed;
  logic        [CNT_W-1:0]   r_pend_pos;
  logic                      r_refill_valid;
  logic        [BYTE_W-1:0]  r_refill_data;
  logic        [CNT_W-1:0]   r_refill_pos;
  logic                      r_err;

  logic                      w_op_ready;
  logic                      w_byte_ready;
  logic                      w_accept;
  logic                      w_byte_hs;
  logic signed [CNT_W-1:0]   w_sum;
  logic                      w_sum_ge0;
  logic                      w_clamped;
  logic signed [CNT_W-1:0]   w_refill_bn;

  // Both step classes advance the counter identically; the flag is informational only.
  logic                      w_unused_bypass;
  assign w_unused_bypass = op_bypass;

  // init wins over any handshake offered in the same cycle.
  assign w_op_ready   = (r_state == ST_RUN) && !init;
  assign w_byte_ready = (r_state == ST_WAIT_BYTE) && !init;
  assign w_accept     = op_valid & w_op_ready;
  assign w_byte_hs    = byte_valid & w_byte_ready;

  bn_step #(
    .CNT_W     (CNT_W),
    .MAX_SHIFT (MAX_SHIFT),
    .SHIFT_W   (SHIFT_W)
  ) u_step (
    .i_bits_needed (r_bits_needed),
    .i_shift       (op_shift),
    .i_pend_pos    (r_pend_pos),
    .o_sum         (w_sum),
    .o_sum_ge0     (w_sum_ge0),
    .o_clamped     (w_clamped),
    .o_refill_bn   (w_refill_bn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_bits_needed  <= c_bn_init;
      r_pend_pos     <= '0;
      r_refill_valid <= 1'b0;
      r_refill_data  <= '0;
      r_refill_pos   <= '0;
      r_err          <= 1'b0;
    end else begin
      r_refill_valid <= 1'b0;
      if (init) begin
        r_state       <= ST_RUN;
        r_bits_needed <= c_bn_init;
        r_err         <= 1'b0;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (w_accept) begin
              if (w_clamped) begin
                r_err <= 1'b1;
              end
              if (w_sum_ge0) begin
                r_pend_pos <= w_sum;
                r_state    <= ST_WAIT_BYTE;
              end else begin
                r_bits_needed <= w_sum;
              end
            end
          end
          ST_WAIT_BYTE: begin
            if (w_byte_hs) begin
              r_refill_valid <= 1'b1;
              r_refill_data  <= byte_data;
              r_refill_pos   <= r_pend_pos;
              r_bits_needed  <= w_refill_bn;
              r_state        <= ST_RUN;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef BN_REFILL_STATS_EN
  logic [31:0] r_byte_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
    end else if (init) begin
      r_byte_cnt <= '0;
    end else if (w_byte_hs) begin
      r_byte_cnt <= r_byte_cnt + 32'd1;
    end
  end

  assign byte_cnt = r_byte_cnt;
`else
  assign byte_cnt = '0;
`endif

  assign op_ready     = w_op_ready;
  assign byte_ready   = w_byte_ready;
  assign refill_valid = r_refill_valid;
  assign refill_data  = r_refill_data;
  assign refill_pos   = r_refill_pos;
  assign bits_needed  = r_bits_needed;
  assign err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bn_refill_ctrl.sv
// tb_bn_refill_ctrl -- directed and randomized checks of bn_refill_ctrl against a cycle model.
// Rev 1.0
`default_nettype none

module tb_bn_refill_ctrl;

  localparam int CNT_W     = 5;
  localparam int MAX_SHIFT = 8;
  localparam int SHIFT_W   = 4;
`ifdef BN_REFILL_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic                     clk;
  logic                     rst_n;
  logic                     init;
  logic                     op_valid;
  logic                     op_ready;
  logic                     op_bypass;
  logic       [SHIFT_W-1:0] op_shift;
  logic                     byte_valid;
  logic       [7:0]         byte_data;
  logic                     byte_ready;
  logic                     refill_valid;
  logic       [7:0]         refill_data;
  logic       [CNT_W-1:0]   refill_pos;
  logic signed [CNT_W-1:0]  bits_needed;
  logic                     err;
  logic       [31:0]        byte_cnt;

  bn_refill_ctrl #(
    .CNT_W     (CNT_W),
    .MAX_SHIFT (MAX_SHIFT),
    .SHIFT_W   (SHIFT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init         (init),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_bypass    (op_bypass),
    .op_shift     (op_shift),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .refill_valid (refill_valid),
    .refill_data  (refill_data),
    .refill_pos   (refill_pos),
    .bits_needed  (bits_needed),
    .err          (err),
    .byte_cnt     (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: started = seen init since reset, waiting = a byte is owed.
  bit      m_started;
  bit      m_waiting;
  int      m_bn;
  int      m_pend;
  bit      m_err;
  longint  m_cnt;
  bit      m_rv;
  int      m_rd;
  int      m_rp;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_waiting = 0; m_bn = -8; m_pend = 0;
    m_err = 0; m_cnt = 0; m_rv = 0; m_rd = 0; m_rp = 0;
  endtask

  task automatic check_regs();
    chk("bits_needed", int'(bits_needed), m_bn);
    chk("refill_valid", int'(refill_valid), int'(m_rv));
    chk("err", int'(err), int'(m_err));
    chk("byte_cnt", int'(byte_cnt), (STATS != 0) ? int'(m_cnt & 64'hFFFF_FFFF) : 0);
    if (m_rv) begin
      chk("refill_data", int'(refill_data), m_rd);
      chk("refill_pos", int'(refill_pos), m_rp);
    end
  endtask

  // One clock cycle: drive, check ready outputs, advance model, check registered outputs.
  task automatic cyc(input bit i_init, input bit i_opv, input bit i_byp,
                     input int i_sh, input bit i_bv, input int i_bd);
    int eff;
    int s;
    bit can_op;
    bit can_byte;
    init       = i_init;
    op_valid   = i_opv;
    op_bypass  = i_byp;
    op_shift   = SHIFT_W'(i_sh);
    byte_valid = i_bv;
    byte_data  = 8'(i_bd);
    #1;
    can_op   = m_started && !m_waiting && !i_init;
    can_byte = m_started && m_waiting && !i_init;
    chk("op_ready", int'(op_ready), int'(can_op));
    chk("byte_ready", int'(byte_ready), int'(can_byte));
    m_rv = 0;
    if (i_init) begin
      m_started = 1; m_waiting = 0; m_bn = -8; m_err = 0; m_cnt = 0;
    end else if (can_byte && i_bv) begin
      m_rv = 1; m_rd = i_bd & 255; m_rp = m_pend;
      m_bn = m_pend - 8; m_waiting = 0; m_cnt++;
    end else if (can_op && i_opv) begin
      eff = (i_sh > MAX_SHIFT) ? MAX_SHIFT : i_sh;
      if (i_sh > MAX_SHIFT) m_err = 1;
      s = m_bn + eff;
      if (s < 0) m_bn = s;
      else begin
        m_pend = s; m_waiting = 1;
      end
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_bn", int'(bits_needed), -8);
    chk("rst_async_refill_valid", int'(refill_valid), 0);
    chk("rst_async_err", int'(err), 0);
    chk("rst_async_byte_cnt", int'(byte_cnt), 0);
    chk("rst_async_refill_data", int'(refill_data), 0);
    chk("rst_async_refill_pos", int'(refill_pos), 0);
    init = 1'b1; op_valid = 1'b1; byte_valid = 1'b1; op_shift = 4'd3;
    #1;
    chk("rst_op_ready", int'(op_ready), 0);
    chk("rst_byte_ready", int'(byte_ready), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_bn", int'(bits_needed), -8);
    chk("rst_hold_op_ready", int'(op_ready), 0);
    init = 1'b0; op_valid = 1'b0; byte_valid = 1'b0; op_shift = '0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    rst_n = 1'b0; init = 0; op_valid = 0; op_bypass = 0;
    op_shift = '0; byte_valid = 0; byte_data = '0;
    model_reset();
    do_reset();

    // Not started yet: a request must be ignored.
    cyc(0, 1, 0, 3, 0, 0);
    chk("idle_ignores_op", int'(bits_needed), -8);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 3, 0, 0);
    chk("regular3_bn", int'(bits_needed), -5);
    chk("regular3_op_ready", int'(op_ready), 1);
    chk("regular3_byte_ready", int'(byte_ready), 0);

    cyc(0, 1, 1, 6, 0, 0);
    chk("bypass6_bn_unchanged", int'(bits_needed), -5);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 8'hA5);
    chk("a5_refill_valid", int'(refill_valid), 1);
    chk("a5_refill_data", int'(refill_data), 8'hA5);
    chk("a5_refill_pos", int'(refill_pos), 1);
    chk("a5_bn", int'(bits_needed), -7);
    cyc(0, 0, 0, 0, 0, 0);
    chk("a5_refill_one_cycle", int'(refill_valid), 0);

    cyc(0, 1, 0, 6, 0, 0);
    chk("to_minus1", int'(bits_needed), -1);
    cyc(0, 1, 0, 1, 0, 0);
    chk("sum0_byte_ready", int'(byte_ready), 1);
    cyc(0, 0, 0, 0, 1, 8'h3C);
    chk("3c_refill_pos", int'(refill_pos), 0);
    chk("3c_refill_data", int'(refill_data), 8'h3C);
    chk("3c_bn", int'(bits_needed), -8);

    cyc(0, 1, 0, 9, 0, 0);
    chk("clamp_err", int'(err), 1);
    chk("clamp_byte_ready", int'(byte_ready), 1);

    cyc(1, 0, 0, 0, 1, 8'h55);
    chk("init_wait_no_refill", int'(refill_valid), 0);
    chk("init_wait_bn", int'(bits_needed), -8);
    chk("init_wait_err_clr", int'(err), 0);
    cyc(1, 1, 0, 3, 0, 0);
    chk("init_op_not_taken", int'(bits_needed), -8);
    cyc(0, 1, 0, 3, 0, 0);
    chk("run_after_init", int'(bits_needed), -5);

    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 1, 8, 0, 0);
      cyc(0, 1, 0, 2, 1, k + 1);
    end
    chk("stats_five", int'(byte_cnt), 5 * STATS);
    cyc(1, 0, 0, 0, 0, 0);
    chk("stats_init_clr", int'(byte_cnt), 0);

    for (int n = 0; n < 3000; n++) begin
      int sh;
      if (n == 1500) do_reset();
      sh = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
          sh, 1'($urandom), int'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
